instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch unit: the initiator side of the instruction-memory read port. Holds the program counter, drives `instr_mem_addr`, and captures the combinational `instr_mem_out` every cycle. Buffers fetched words in a 2-entry FIFO and presents them to decode over a valid/ready handshake. Accepts branch/jump redirects and halts on a misaligned PC.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `fetch_clk` in 1: clock, rising-edge.
- `fetch_rst_n` in 1: reset, asynchronous, active-low.
- `instr_mem_addr` out 32: byte address to instruction memory; equals the PC register.
- `instr_mem_out` in 32: instruction word, combinational from `instr_mem_addr` in the same cycle.
- `redirect_valid` in 1: load a new PC this cycle (branch/jump taken).
- `redirect_pc` in 32: redirect target byte address.
- `fetch_valid` out 1: FIFO head holds a valid entry.
- `fetch_ready` in 1: decode accepts the head this cycle.
- `fetch_instr` out 32: head instruction; 0 when FIFO is empty.
- `fetch_pc` out 32: head PC; 0 when FIFO is empty.
- `fetch_misalign` out 1: head entry came from a PC with `[1:0]!=0`; 0 when FIFO is empty.
- `fetch_halted` out 1: FSM is in HALT.

## Operation
- State: PC register (32b), FIFO of 2 entries `{pc[31:0], instr[31:0], misalign}`, count 0..2, FSM {RUN, HALT}.
- pop = `fetch_valid & fetch_ready`.
- push = (state==RUN) & (count<2 | pop) & ~`redirect_valid`.
- On push:
  - Write `{PC, instr_mem_out, PC[1:0]!=0}` at the tail.
  - If PC is aligned, PC <= PC + 4. Arithmetic is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
  - If PC is misaligned, PC holds and the FSM goes RUN -> HALT. The misalign entry is still pushed so decode receives `fetch_misalign`=1.
- Push and pop in the same cycle with count=2: count stays 2.
- `fetch_halted`: HALT stops all pushes. Pops continue until the FIFO drains.
- `redirect_valid` has top priority over push, pop and the FSM:
  - FIFO is flushed (count <= 0).
  - PC <= `redirect_pc`.
  - FSM <= RUN.
  - A pop asserted in the same cycle is still counted as consumed by decode.
  - The memory word read that cycle is discarded.
- A misaligned `redirect_pc` is fetched normally on the next cycle, producing one misalign entry, then HALT.
- HALT -> RUN only via `redirect_valid`.

## Timing
- Reset values (asynchronous, while `fetch_rst_n`=0):
  - PC = `RESET_PC`, so `instr_mem_addr` = `RESET_PC`.
  - count = 0, FSM = RUN.
  - `fetch_valid`=0, `fetch_instr`=0, `fetch_pc`=0, `fetch_misalign`=0, `fetch_halted`=0.
- Reset deassertion mid-operation requires nothing special. Reset asserted at any time clears the FIFO and PC immediately.
- Latency:
  - First rising edge after reset release pushes `RESET_PC`; `fetch_valid`=1 after that edge.
  - After a redirect edge, `instr_mem_addr`=`redirect_pc` combinationally. The target entry is pushed on the next edge and `fetch_valid` rises after it (1-cycle bubble).
- Throughput: one instruction per cycle while `fetch_ready`=1.
- With `fetch_ready`=0, the FIFO fills in 2 cycles. PC then holds and `instr_mem_addr` is stable.
- Handshake:
  - `fetch_instr`, `fetch_pc` and `fetch_misalign` are stable while `fetch_valid`=1 and `fetch_ready`=0.
  - `fetch_valid` never drops without a pop, a redirect or a reset.
- All outputs are registered or decoded from registers. `instr_mem_out` feeds only FIFO write data; there is no combinational path from `instr_mem_out` to outputs.

## Test plan
- **Reset and stream.** Memory holds word[0]=32'h0001A003, word[1]=32'h0011A083, word[2]=32'h00008133. Release reset with `fetch_ready`=1. Decode must see pc 0, 4, 8 with those words on consecutive cycles after the first edge.
- **Backpressure.** Hold `fetch_ready`=0 for 5 cycles. Required: count saturates at 2, `instr_mem_addr` freezes at 8, head stays pc=0. Then release `fetch_ready`; no word is lost or duplicated.
- **Redirect.**
  - Assert `redirect_valid` with `redirect_pc`=56 while the FIFO is full. FIFO is flushed; `fetch_valid`=0 for one cycle.
  - Next entry is pc=56, instr=32'h00B18213.
  - Also assert `fetch_ready` on the redirect cycle and check the flush still happens.
- **Misaligned redirect.** Redirect to 32'h0000_0006, memory returning 32'hFFFF_FFFF. Required:
  - One entry pc=6, instr=32'hFFFF_FFFF, `fetch_misalign`=1.
  - Then `fetch_halted`=1 and no further pushes.
  - Redirect to 0 resumes RUN.
- **Wrap-around.** `RESET_PC`=32'hFFFF_FFF8. Entries must be pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Async reset mid-stream.** Pull `fetch_rst_n` low between edges with 2 entries buffered. Required: outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction-memory read port, redirect input and decode handshake of the fetch unit.
interface instruction_fetch_if;
   logic [31:0] instr_mem_addr;
   logic [31:0] instr_mem_out;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_instr;
   logic [31:0] fetch_pc;
   logic        fetch_misalign;
   logic        fetch_halted;

   modport master (
      output instr_mem_addr,
      input  instr_mem_out,
      input  redirect_valid,
      input  redirect_pc,
      output fetch_valid,
      input  fetch_ready,
      output fetch_instr,
      output fetch_pc,
      output fetch_misalign,
      output fetch_halted
   );

   modport slave (
      input  instr_mem_addr,
      output instr_mem_out,
      output redirect_valid,
      output redirect_pc,
      input  fetch_valid,
      output fetch_ready,
      input  fetch_instr,
      input  fetch_pc,
      input  fetch_misalign,
      input  fetch_halted
   );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, 2-entry fetch FIFO with valid/ready to decode, redirects and misalign halt.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic               fetch_clk,
   input logic               fetch_rst_n,
   instruction_fetch_if.master bus
);
   typedef enum logic {RUN, HALT} state_t;

   state_t      state, state_nx;
   logic [31:0] pc;
   logic [31:0] fifo_pc    [2];
   logic [31:0] fifo_instr [2];
   logic        fifo_mis   [2];
   logic [1:0]  count;
   logic        rd_ptr, wr_ptr;
   logic        valid, pop, push, pc_mis;

   assign pc_mis = pc[1:0] != 2'b00;
   assign valid  = count != 2'd0;
   assign pop    = valid & bus.fetch_ready;

   always_ff @(posedge fetch_clk or negedge fetch_rst_n) begin
      if (!fetch_rst_n) state <= RUN;
      else              state <= state_nx;
   end

   // a misaligned fetch still pushes its entry, then the unit parks until redirected
   always_comb begin
      state_nx = bus.redirect_valid ? RUN : (push & pc_mis) ? HALT : state;
   end

   always_comb begin
      push             = (state == RUN) & ((count != 2'd2) | pop) & ~bus.redirect_valid;
      bus.fetch_halted = state == HALT;
   end

   always_ff @(posedge fetch_clk or negedge fetch_rst_n) begin
      if (!fetch_rst_n) begin
         pc     <= RESET_PC;
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else if (bus.redirect_valid) begin
         pc     <= bus.redirect_pc;
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (push) begin
            pc     <= pc_mis ? pc : pc + 32'd4;
            wr_ptr <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge fetch_clk or negedge fetch_rst_n) begin
      if (!fetch_rst_n) begin
         for (int i = 0; i < 2; i++) begin
            fifo_pc[i]    <= 32'd0;
            fifo_instr[i] <= 32'd0;
            fifo_mis[i]   <= 1'b0;
         end
      end else if (push) begin
         fifo_pc[wr_ptr]    <= pc;
         fifo_instr[wr_ptr] <= bus.instr_mem_out;
         fifo_mis[wr_ptr]   <= pc_mis;
      end
   end

   assign bus.instr_mem_addr = pc;
   assign bus.fetch_valid    = valid;
   assign bus.fetch_instr    = valid ? fifo_instr[rd_ptr] : 32'd0;
   assign bus.fetch_pc       = valid ? fifo_pc[rd_ptr] : 32'd0;
   assign bus.fetch_misalign = valid & fifo_mis[rd_ptr];
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of streaming, backpressure, redirects, misalign halt, wrap and async reset.
module tb_instruction_fetch;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic rst2_n = 1'b1;
   int   n_checks = 0;
   int   n_pass = 0;

   instruction_fetch_if bus ();
   instruction_fetch_if bus2 ();

   instruction_fetch dut (.fetch_clk(clk), .fetch_rst_n(rst_n), .bus(bus));
   instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (.fetch_clk(clk), .fetch_rst_n(rst2_n), .bus(bus2));

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a[1:0] != 2'b00) return 32'hFFFF_FFFF;
      case (a)
         32'd0:   return 32'h0001_A003;
         32'd4:   return 32'h0011_A083;
         32'd8:   return 32'h0000_8133;
         32'd56:  return 32'h00B1_8213;
         default: return 32'h1357_0000 ^ a;
      endcase
   endfunction

   always_comb bus.instr_mem_out = mem(bus.instr_mem_addr);
   always_comb bus2.instr_mem_out = mem(bus2.instr_mem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic head(input string tag, input logic [31:0] p, input logic [31:0] i, input logic m);
      check({tag, " valid"}, 32'(bus.fetch_valid), 32'd1);
      check({tag, " pc"}, bus.fetch_pc, p);
      check({tag, " instr"}, bus.fetch_instr, i);
      check({tag, " misalign"}, 32'(bus.fetch_misalign), 32'(m));
   endtask

   task automatic empty(input string tag);
      check({tag, " valid"}, 32'(bus.fetch_valid), 32'd0);
      check({tag, " pc"}, bus.fetch_pc, 32'd0);
      check({tag, " instr"}, bus.fetch_instr, 32'd0);
      check({tag, " misalign"}, 32'(bus.fetch_misalign), 32'd0);
   endtask

   initial begin
      bus.fetch_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'd0;
      bus2.fetch_ready = 1'b1;
      bus2.redirect_valid = 1'b0;
      bus2.redirect_pc = 32'd0;
      rst_n = 1'b0;
      rst2_n = 1'b0;
      #2;
      empty("reset");
      check("reset addr", bus.instr_mem_addr, 32'd0);
      check("reset halted", 32'(bus.fetch_halted), 32'd0);
      #10 rst_n = 1'b1;
      step();
      head("stream0", 32'd0, 32'h0001_A003, 1'b0);
      check("stream0 addr", bus.instr_mem_addr, 32'd4);
      step();
      head("stream1", 32'd4, 32'h0011_A083, 1'b0);
      step();
      head("stream2", 32'd8, 32'h0000_8133, 1'b0);
      check("stream2 addr", bus.instr_mem_addr, 32'd12);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'd0;
      step();
      empty("restart");
      check("restart addr", bus.instr_mem_addr, 32'd0);
      bus.redirect_valid = 1'b0;
      bus.fetch_ready = 1'b0;
      step();
      head("bp0", 32'd0, 32'h0001_A003, 1'b0);
      check("bp0 addr", bus.instr_mem_addr, 32'd4);
      step();
      head("bp1", 32'd0, 32'h0001_A003, 1'b0);
      check("bp1 addr", bus.instr_mem_addr, 32'd8);
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp hold pc", bus.fetch_pc, 32'd0);
         check("bp hold addr", bus.instr_mem_addr, 32'd8);
      end
      bus.fetch_ready = 1'b1;
      step();
      head("bp rel0", 32'd4, 32'h0011_A083, 1'b0);
      step();
      head("bp rel1", 32'd8, 32'h0000_8133, 1'b0);
      check("bp rel1 addr", bus.instr_mem_addr, 32'd16);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'd56;
      #1;
      check("redir pre valid", 32'(bus.fetch_valid), 32'd1);
      step();
      empty("redir flush");
      check("redir addr", bus.instr_mem_addr, 32'd56);
      bus.redirect_valid = 1'b0;
      bus.fetch_ready = 1'b0;
      step();
      head("redir tgt", 32'd56, 32'h00B1_8213, 1'b0);
      check("redir tgt addr", bus.instr_mem_addr, 32'd60);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'd6;
      bus.fetch_ready = 1'b1;
      step();
      empty("mis flush");
      check("mis addr", bus.instr_mem_addr, 32'd6);
      bus.redirect_valid = 1'b0;
      bus.fetch_ready = 1'b0;
      step();
      head("mis entry", 32'd6, 32'hFFFF_FFFF, 1'b1);
      check("mis halted", 32'(bus.fetch_halted), 32'd1);
      check("mis addr hold", bus.instr_mem_addr, 32'd6);
      bus.fetch_ready = 1'b1;
      step();
      check("halt drain valid", 32'(bus.fetch_valid), 32'd0);
      check("halt drain halted", 32'(bus.fetch_halted), 32'd1);
      step();
      check("halt idle valid", 32'(bus.fetch_valid), 32'd0);
      check("halt idle addr", bus.instr_mem_addr, 32'd6);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'd0;
      step();
      check("resume halted", 32'(bus.fetch_halted), 32'd0);
      empty("resume");
      bus.redirect_valid = 1'b0;
      bus.fetch_ready = 1'b0;
      step();
      head("resume0", 32'd0, 32'h0001_A003, 1'b0);
      step();
      check("resume full addr", bus.instr_mem_addr, 32'd8);
      #3 rst_n = 1'b0;
      #1;
      empty("async rst");
      check("async rst addr", bus.instr_mem_addr, 32'd0);
      check("async rst halted", 32'(bus.fetch_halted), 32'd0);
      #2 rst2_n = 1'b1;
      step();
      check("wrap0 valid", 32'(bus2.fetch_valid), 32'd1);
      check("wrap0 pc", bus2.fetch_pc, 32'hFFFF_FFF8);
      check("wrap0 instr", bus2.fetch_instr, 32'hECA8_FFF8);
      step();
      check("wrap1 pc", bus2.fetch_pc, 32'hFFFF_FFFC);
      step();
      check("wrap2 pc", bus2.fetch_pc, 32'h0000_0000);
      check("wrap2 instr", bus2.fetch_instr, 32'h0001_A003);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
